fifo_wr_arbiter: RTL

Write-side arbiter that shares the single write port of the FIFO memory between `N_Req` requesters in the `w_clk` domain. It grants requesters in round-robin order, holds each grant for a bounded burst, and generates `w_inc`/`wdata` directly into the memory. It honours `wfull` so that no beat is lost or duplicated.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1 (mod N_Req).
module rr_pick #(
    parameter int N_Req = 4,
    parameter int Id_W  = 2
) (
    input  logic [N_Req-1:0] req,
    input  logic [Id_W-1:0]  last,
    output logic [Id_W-1:0]  winner,
    output logic             any
);

    // Walk the rotation backwards so the closest requester after last wins.
    always_comb begin
        winner = '0;
        for (int i = N_Req; i >= 1; i--) begin
            if (req[(int'(last) + i) % N_Req]) begin
                winner = Id_W'((int'(last) + i) % N_Req);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: bounded bursts per grant, stalls on wfull.
//
// state | meaning
// IDLE  | no grant; arbitrate among req for the next cycle
// GRANT | owner drives the FIFO write port until burst limit or req drop
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int D_Size    = 8,
    parameter int N_Req     = 4,
    parameter int Max_Burst = 8
) (
    input  logic                       w_clk,
    input  logic                       w_rst,
    input  logic [N_Req-1:0]           req,
    input  logic [N_Req*D_Size-1:0]    req_data,
    input  logic                       wfull,
    output logic [N_Req-1:0]           ready,
    output logic [N_Req-1:0]           gnt,
    output logic [id_width(N_Req)-1:0] owner,
    output logic                       busy,
    output logic                       w_inc,
    output logic [D_Size-1:0]          wdata
);

    localparam int Id_W  = id_width(N_Req);
    localparam int Cnt_W = $clog2(Max_Burst + 1);
    localparam logic [Cnt_W-1:0] Last_Cnt = Cnt_W'(Max_Burst - 1);

    arb_state_t        state, state_n;
    logic [N_Req-1:0]  gnt_n;
    logic [Id_W-1:0]   owner_n;
    logic [Id_W-1:0]   last, last_n;
    logic [Cnt_W-1:0]  cnt, cnt_n;
    logic [Id_W-1:0]   pick_winner;
    logic              pick_any;
    logic              req_own;

    rr_pick #(
        .N_Req (N_Req),
        .Id_W  (Id_W)
    ) u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign busy    = (state == GRANT);
    assign req_own = req[owner];
    assign w_inc   = busy & req_own & ~wfull;
    assign ready   = gnt & {N_Req{~wfull}};

    // Write data follows the owner only while a grant is active.
    always_comb begin
        wdata = '0;
        if (busy) begin
            wdata = req_data[int'(owner)*D_Size +: D_Size];
        end
    end

    // Next-state: arbitrate in IDLE, count beats and decide release in GRANT.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner;
        last_n  = last;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n            = GRANT;
                    gnt_n              = '0;
                    gnt_n[pick_winner] = 1'b1;
                    owner_n            = pick_winner;
                    last_n             = pick_winner;
                    cnt_n              = '0;
                end
            end
            GRANT: begin
                // A dropped request releases even under wfull; a full FIFO
                // on the last beat keeps the grant because no beat was taken.
                if (!req_own || (w_inc && (cnt == Last_Cnt))) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    cnt_n   = '0;
                end else if (w_inc) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // State and grant registers; reset abandons any burst in progress.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            last  <= Id_W'(N_Req - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            owner <= owner_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

endmodule
